tile_renderer: RTL and testbench

TILE_RENDERER -- requirements
Module: tile_renderer

---
 rtl/tile_renderer_pkg.sv | 45 ++++
 rtl/tile_renderer_if.sv | 38 +++
 rtl/tile_renderer_tile_ram.sv | 46 ++++
 rtl/tile_renderer.sv | 194 +++++++++++++++++++
 tb/tb_tile_renderer.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tile_renderer_pkg.sv
// Shared constants and types for the character-tile LCD renderer.
// Holds tile geometry, RGB565 colour type, tile-entry field layout and ROM image names.
// No logic; imported by the renderer and its interface.
package tile_renderer_pkg;

   // Tile geometry in pixels
   localparam int TILE_W = 8;
   localparam int TILE_H = 8;

   // ROM geometry: 256 glyphs x 8 rows, 16 palette entries
   localparam int FONT_DEPTH    = 2048;
   localparam int PALETTE_DEPTH = 16;

   // Tile-map entry layout: [15:12] fg, [11:8] bg, [7:0] char code
   localparam int ENTRY_W  = 16;
   localparam int FG_LSB   = 12;
   localparam int FG_W     = 4;
   localparam int BG_LSB   = 8;
   localparam int BG_W     = 4;
   localparam int CHAR_LSB = 0;
   localparam int CHAR_W   = 8;

   // ROM image names used by the memory-initialisation flow
   localparam string FONT_FILE    = "font.hex";
   localparam string PALETTE_FILE = "palette.hex";

   typedef struct packed {
      logic [4:0] red;
      logic [5:0] green;
      logic [4:0] blue;
   } rgb565_t;

   function automatic logic [FG_W-1:0] entry_fg(input logic [ENTRY_W-1:0] e);
      return e[FG_LSB +: FG_W];
   endfunction

   function automatic logic [BG_W-1:0] entry_bg(input logic [ENTRY_W-1:0] e);
      return e[BG_LSB +: BG_W];
   endfunction

   function automatic logic [CHAR_W-1:0] entry_char(input logic [ENTRY_W-1:0] e);
      return e[CHAR_LSB +: CHAR_W];
   endfunction

endpackage

// File: rtl/tile_renderer_if.sv
// Bus bundle between the panel driver / host and the tile renderer.
// Carries raster position, vsync, tile-map write port, scroll register write and RGB565 out.
// No flow control: position is sampled every cycle, writes are single-cycle strobes.
interface tile_renderer_if #(
   parameter int WIDTH  = 128,
   parameter int HEIGHT = 160,
   parameter int COLS   = 16,
   parameter int ROWS   = 20
);
   localparam int VW = $clog2(HEIGHT);
   localparam int HW = $clog2(WIDTH);
   localparam int AW = $clog2(COLS*ROWS);

   logic [VW-1:0] vpos;
   logic [HW-1:0] hpos;
   logic          vsync;
   logic          we;
   logic [AW-1:0] waddr;
   logic [15:0]   wdata;
   logic          scroll_we;
   logic [7:0]    scroll_data;
   logic [4:0]    red;
   logic [5:0]    green;
   logic [4:0]    blue;

   // Driver side: panel timing + host writes, receives colour
   modport master (
      output vpos, hpos, vsync, we, waddr, wdata, scroll_we, scroll_data,
      input  red, green, blue
   );

   // Renderer side
   modport slave (
      input  vpos, hpos, vsync, we, waddr, wdata, scroll_we, scroll_data,
      output red, green, blue
   );

endinterface

// File: rtl/tile_renderer_tile_ram.sv
// Tile map storage: single write port, single registered read port, read-first.
// Latency: read data valid one cycle after raddr is presented.
// No backpressure; writes beyond DEPTH are dropped. Ports: cin, reset, we/waddr/wdata, raddr/rdata.
module tile_ram #(
   parameter int DEPTH = 320,
   parameter int AW    = $clog2(DEPTH),
   parameter int DW    = 16
) (
   input  logic          cin,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];
   logic          wen;

   // Only guard the write when the address space is larger than the array
   generate
      if ((1 << AW) == DEPTH) begin : g_full
         assign wen = we;
      end else begin : g_guard
         assign wen = we && (waddr < AW'(DEPTH));
      end
   endgenerate

   // Contents are deliberately not reset
   always_ff @(posedge cin) begin
      if (wen) begin
         mem[waddr] <= wdata;
      end
   end

   // Nonblocking read of the pre-write contents gives read-first behaviour
   always_ff @(posedge cin or negedge reset) begin
      if (!reset) begin
         rdata <= '0;
      end else begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/tile_renderer.sv
// Character-tile renderer: raster position + vertical scroll -> tile map -> font -> palette -> RGB565.
// Latency: colour for a vpos/hpos appears on the 4th posedge of cin after it is applied.
// No backpressure: one pixel per cycle; ports are cin, reset (async active-low) and the slave bus.
module tile_renderer
   import tile_renderer_pkg::*;
#(
   parameter int WIDTH  = 128,
   parameter int HEIGHT = 160,
   parameter int COLS   = 16,
   parameter int ROWS   = 20
) (
   input  logic           cin,
   input  logic           reset,
   tile_renderer_if.slave bus
);

   localparam int VW    = $clog2(HEIGHT);
   localparam int HW    = $clog2(WIDTH);
   localparam int DEPTH = COLS*ROWS;
   localparam int AW    = $clog2(DEPTH);
   localparam int FW    = $clog2(TILE_W);
   localparam int FH    = $clog2(TILE_H);

   // ROMs: contents come from FONT_FILE / PALETTE_FILE images, untouched by reset
   logic [TILE_W-1:0]  font_rom [FONT_DEPTH];
   logic [ENTRY_W-1:0] palette  [PALETTE_DEPTH];

   // ---------------------------------------------------------------
   // Scroll registers
   // ---------------------------------------------------------------
   logic       vsync_q;
   logic [7:0] scroll_shadow;
   logic [7:0] scroll_active;
   logic       scroll_ok;

   assign scroll_ok = ({1'b0, bus.scroll_data} < 9'(HEIGHT));

   // The active value only moves on a vsync rise so a frame never tears;
   // a same-edge shadow write lands after the transfer has taken the old value.
   always_ff @(posedge cin or negedge reset) begin
      if (!reset) begin
         vsync_q       <= 1'b0;
         scroll_shadow <= '0;
         scroll_active <= '0;
      end else begin
         vsync_q <= bus.vsync;
         if (bus.scroll_we && scroll_ok) begin
            scroll_shadow <= bus.scroll_data;
         end
         if (bus.vsync && !vsync_q) begin
            scroll_active <= scroll_shadow;
         end
      end
   end

   // ---------------------------------------------------------------
   // Stage 1: position / scroll
   // ---------------------------------------------------------------
   logic          vpos_oob;
   logic          hpos_oob;
   logic          show;
   logic [VW:0]   line_sum;
   logic [VW-1:0] line;
   logic [AW-1:0] tidx;

   generate
      if ((1 << VW) == HEIGHT) begin : g_vfull
         assign vpos_oob = 1'b0;
      end else begin : g_vchk
         assign vpos_oob = (bus.vpos >= VW'(HEIGHT));
      end
      if ((1 << HW) == WIDTH) begin : g_hfull
         assign hpos_oob = 1'b0;
      end else begin : g_hchk
         assign hpos_oob = (bus.hpos >= HW'(WIDTH));
      end
   endgenerate

   assign show     = !(vpos_oob || hpos_oob);
   assign line_sum = {1'b0, bus.vpos} + (VW+1)'(scroll_active);
   // Single wrap is enough: both terms are below HEIGHT for visible lines
   assign line     = (line_sum >= (VW+1)'(HEIGHT)) ? VW'(line_sum - (VW+1)'(HEIGHT))
                                                   : line_sum[VW-1:0];
   assign tidx     = AW'(line[VW-1:FH]) * AW'(COLS) + AW'(bus.hpos[HW-1:FW]);

   logic          s1_show;
   logic [AW-1:0] s1_tidx;
   logic [FH-1:0] s1_frow;
   logic [FW-1:0] s1_fcol;

   always_ff @(posedge cin or negedge reset) begin
      if (!reset) begin
         s1_show <= 1'b0;
         s1_tidx <= '0;
         s1_frow <= '0;
         s1_fcol <= '0;
      end else begin
         s1_show <= show;
         // Park off-screen reads on entry 0 so the RAM is never addressed past DEPTH
         s1_tidx <= show ? tidx : '0;
         s1_frow <= line[FH-1:0];
         s1_fcol <= bus.hpos[FW-1:0];
      end
   end

   // ---------------------------------------------------------------
   // Stage 2: tile-map read
   // ---------------------------------------------------------------
   logic [ENTRY_W-1:0] tile_q;
   logic               s2_show;
   logic [FH-1:0]      s2_frow;
   logic [FW-1:0]      s2_fcol;

   tile_ram #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (ENTRY_W)
   ) u_tile_ram (
      .cin   (cin),
      .reset (reset),
      .we    (bus.we),
      .waddr (bus.waddr),
      .wdata (bus.wdata),
      .raddr (s1_tidx),
      .rdata (tile_q)
   );

   always_ff @(posedge cin or negedge reset) begin
      if (!reset) begin
         s2_show <= 1'b0;
         s2_frow <= '0;
         s2_fcol <= '0;
      end else begin
         s2_show <= s1_show;
         s2_frow <= s1_frow;
         s2_fcol <= s1_fcol;
      end
   end

   // ---------------------------------------------------------------
   // Stage 3: font read
   // ---------------------------------------------------------------
   logic [CHAR_W+FH-1:0] font_addr;
   logic [TILE_W-1:0]    font_q;
   logic [FG_W-1:0]      s3_fg;
   logic [BG_W-1:0]      s3_bg;
   logic [FW-1:0]        s3_fcol;
   logic                 s3_show;

   assign font_addr = {entry_char(tile_q), s2_frow};

   always_ff @(posedge cin or negedge reset) begin
      if (!reset) begin
         font_q  <= '0;
         s3_fg   <= '0;
         s3_bg   <= '0;
         s3_fcol <= '0;
         s3_show <= 1'b0;
      end else begin
         font_q  <= font_rom[font_addr];
         s3_fg   <= entry_fg(tile_q);
         s3_bg   <= entry_bg(tile_q);
         s3_fcol <= s2_fcol;
         s3_show <= s2_show;
      end
   end

   // ---------------------------------------------------------------
   // Stage 4: palette select and output register
   // ---------------------------------------------------------------
   logic [FW-1:0] bit_sel;
   logic          pix;
   rgb565_t       colour;
   rgb565_t       rgb;

   // Glyph rows are stored MSB = leftmost pixel
   assign bit_sel = FW'(TILE_W - 1) - s3_fcol;
   assign pix     = font_q[bit_sel];
   assign colour  = rgb565_t'(palette[pix ? s3_fg : s3_bg]);

   // show is cleared by reset, so flushed stages emit black until refilled
   always_ff @(posedge cin or negedge reset) begin
      if (!reset) begin
         rgb <= '0;
      end else begin
         rgb <= s3_show ? colour : '0;
      end
   end

   assign bus.red   = rgb.red;
   assign bus.green = rgb.green;
   assign bus.blue  = rgb.blue;

endmodule

// File: tb/tb_tile_renderer.sv
// Self-checking bench for tile_renderer: scoreboard of expected colours due 4 edges after drive.
// Covers reset, font/palette select, scroll transfer rules, off-screen, read-first and mid-frame reset.
// ROM images are preloaded directly into the renderer arrays.
`timescale 1ns/1ps
module tb_tile_renderer;
   import tile_renderer_pkg::*;

   localparam int WIDTH  = 128;
   localparam int HEIGHT = 160;
   localparam int COLS   = 16;
   localparam int ROWS   = 20;
   localparam int DEPTH  = COLS*ROWS;

   logic cin   = 1'b0;
   logic reset = 1'b1;

   always #5 cin = ~cin;

   tile_renderer_if #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .COLS(COLS), .ROWS(ROWS)) bus ();

   tile_renderer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .COLS(COLS), .ROWS(ROWS)) dut (
      .cin   (cin),
      .reset (reset),
      .bus   (bus)
   );

   logic [15:0] rgb_obs;
   assign rgb_obs = {bus.red, bus.green, bus.blue};

   // Reference contents
   logic [15:0] tm [DEPTH];
   logic [7:0]  fm [FONT_DEPTH];
   logic [15:0] pm [PALETTE_DEPTH];
   int          model_scroll = 0;
   int          model_shadow = 0;

   typedef struct {
      logic [15:0] exp;
      int          due;
      string       tag;
   } sb_t;

   sb_t sb [$];
   int  checks = 0;
   int  errors = 0;
   int  cyc    = 0;

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] model_colour(input int v, input int h, input int scr);
      int          l;
      int          idx;
      logic [15:0] e;
      logic [7:0]  bits;
      if (v >= HEIGHT || h >= WIDTH) return 16'h0000;
      l = v + scr;
      if (l >= HEIGHT) l = l - HEIGHT;
      idx  = (l / 8) * COLS + h / 8;
      e    = tm[idx];
      bits = fm[int'(e[7:0]) * 8 + l % 8];
      return bits[7 - h % 8] ? pm[e[15:12]] : pm[e[11:8]];
   endfunction

   task automatic push_exp(input logic [15:0] exp, input int due, input string tag);
      sb_t e;
      e.exp = exp;
      e.due = due;
      e.tag = tag;
      sb.push_back(e);
   endtask

   // Present a position on the falling edge; its colour is due 4 rising edges later
   task automatic drive(input int v, input int h, input logic [15:0] exp, input string tag);
      @(negedge cin);
      bus.we        = 1'b0;
      bus.scroll_we = 1'b0;
      bus.vpos      = 8'(v);
      bus.hpos      = 7'(h);
      push_exp(exp, cyc + 4, tag);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 20) begin
         @(negedge cin);
         n++;
      end
      if (sb.size() > 0) begin
         check_val("drain_timeout", 16'(sb.size()), 16'h0000);
         sb.delete();
      end
   endtask

   task automatic write_scroll(input int val);
      @(negedge cin);
      bus.we          = 1'b0;
      bus.scroll_we   = 1'b1;
      bus.scroll_data = 8'(val);
      if (val < HEIGHT) model_shadow = val;
      @(negedge cin);
      bus.scroll_we = 1'b0;
   endtask

   task automatic vsync_pulse(input int hi_cycles);
      @(negedge cin);
      bus.we        = 1'b0;
      bus.scroll_we = 1'b0;
      bus.vsync     = 1'b1;
      model_scroll  = model_shadow;
      repeat (hi_cycles) @(negedge cin);
      bus.vsync = 1'b0;
      @(negedge cin);
   endtask

   task automatic sweep(input int n, input string name);
      int v;
      int h;
      for (int k = 0; k < n; k++) begin
         v = $urandom_range(0, HEIGHT + 15);
         h = $urandom_range(0, WIDTH - 1);
         drive(v, h, model_colour(v, h, model_scroll), $sformatf("%s_%0d_v%0d_h%0d", name, k, v, h));
      end
      drain();
   endtask

   // Monitor: compare every entry whose due edge has just happened
   initial begin
      sb_t e;
      forever begin
         @(posedge cin);
         cyc++;
         #1;
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check_val(e.tag, rgb_obs, e.exp);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog cycles %0d expected completion", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] exp_old;
      logic [15:0] new_ent;
      int          p;
      int          rv;
      int          rh;
      int          c;

      bus.vpos        = '0;
      bus.hpos        = '0;
      bus.vsync       = 1'b0;
      bus.we          = 1'b0;
      bus.waddr       = '0;
      bus.wdata       = '0;
      bus.scroll_we   = 1'b0;
      bus.scroll_data = '0;

      for (int i = 0; i < FONT_DEPTH; i++) fm[i] = 8'($urandom);
      fm[16'h41 * 8] = 8'h80;
      for (int i = 0; i < PALETTE_DEPTH; i++) pm[i] = 16'($urandom);
      pm[1] = 16'hF800;
      pm[2] = 16'h001F;
      for (int i = 0; i < FONT_DEPTH; i++) dut.font_rom[i] = fm[i];
      for (int i = 0; i < PALETTE_DEPTH; i++) dut.palette[i] = pm[i];

      #1 reset = 1'b0;
      #1 check_val("reset_rgb", rgb_obs, 16'h0000);
      repeat (2) @(negedge cin);
      reset = 1'b1;

      // Fill tile map through the write port
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge cin);
         tm[i]     = (i == 0) ? 16'h1241 : 16'($urandom);
         bus.we    = 1'b1;
         bus.waddr = 9'(i);
         bus.wdata = tm[i];
      end
      // Writes beyond the map must be dropped
      for (int i = DEPTH; i < 512; i += 17) begin
         @(negedge cin);
         bus.we    = 1'b1;
         bus.waddr = 9'(i);
         bus.wdata = 16'($urandom);
      end
      @(negedge cin);
      bus.we = 1'b0;

      // Known-glyph pixels
      drive(0, 0, 16'hF800, "tile0_px0_red");
      drive(0, 1, 16'h001F, "tile0_px1_blue");
      drive(0, 1, 16'h001F, "tile0_px1_hold");
      drain();

      // Off-screen lines give black
      drive(160, 5, 16'h0000, "oob_v160");
      drive(255, 127, 16'h0000, "oob_v255");
      drive(0, 0, 16'hF800, "after_oob");
      drain();

      sweep(120, "base");

      // Mid-frame scroll write must not take effect before vsync
      write_scroll(8);
      sweep(10, "pre_vsync");
      vsync_pulse(20);
      for (int h = 0; h < WIDTH; h += 13) begin
         drive(0, h, model_colour(0, h, 8), $sformatf("scr8_v0_h%0d", h));
         drive(152, h, model_colour(152, h, 8), $sformatf("scr8_v152_h%0d", h));
      end
      drain();

      // Out-of-range scroll is ignored
      write_scroll(200);
      vsync_pulse(5);
      sweep(10, "scr200_ign");

      // vsync held high: one transfer only
      @(negedge cin);
      bus.vsync = 1'b1;
      model_scroll = model_shadow;
      write_scroll(24);
      repeat (10) @(negedge cin);
      sweep(8, "vs_held");
      @(negedge cin);
      bus.vsync = 1'b0;
      vsync_pulse(3);
      sweep(10, "scr24");

      // Shadow write on the transfer edge: active takes the previous shadow
      @(negedge cin);
      bus.vsync       = 1'b1;
      bus.scroll_we   = 1'b1;
      bus.scroll_data = 8'd40;
      model_scroll    = model_shadow;
      model_shadow    = 40;
      @(negedge cin);
      bus.scroll_we = 1'b0;
      repeat (3) @(negedge cin);
      bus.vsync = 1'b0;
      @(negedge cin);
      sweep(10, "same_edge");
      vsync_pulse(3);
      sweep(10, "scr40");

      // Read-first: write entry 5 on the edge the renderer reads it (v120+40 wraps to row 0)
      exp_old = model_colour(120, 40, model_scroll);
      p = 0;
      while (p < 15 && pm[p] == exp_old) p++;
      new_ent = {4'(p), 4'(p), 8'h00};
      drive(120, 40, exp_old, "rf_old");
      drive(120, 40, pm[p], "rf_new");
      bus.we    = 1'b1;
      bus.waddr = 9'd5;
      bus.wdata = new_ent;
      tm[5] = new_ent;
      drive(120, 40, pm[p], "rf_new_hold");
      drain();

      // Mid-frame reset with scroll 8 active
      write_scroll(8);
      vsync_pulse(3);
      rv = 0;
      rh = 0;
      for (int t = 0; t < 64; t++) begin
         rv = $urandom_range(0, HEIGHT - 1);
         rh = $urandom_range(0, WIDTH - 1);
         if (model_colour(rv, rh, 8) != model_colour(rv, rh, 0)) break;
      end
      drive(rv, rh, model_colour(rv, rh, 8), "pre_reset_scr8");
      drain();
      @(negedge cin);
      reset = 1'b0;
      sb.delete();
      #1 check_val("reset_immediate", rgb_obs, 16'h0000);
      repeat (3) @(negedge cin);
      reset = 1'b1;
      model_scroll = 0;
      model_shadow = 0;
      c = cyc;
      push_exp(16'h0000, c + 1, "rst_edge1");
      push_exp(16'h0000, c + 2, "rst_edge2");
      push_exp(16'h0000, c + 3, "rst_edge3");
      push_exp(model_colour(rv, rh, 0), c + 4, "rst_edge4_scr0");
      drain();
      vsync_pulse(3);
      drive(rv, rh, model_colour(rv, rh, 0), "rst_shadow_cleared");
      drain();
      sweep(10, "post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
